// File: rtl/reg_file_dump.sv
// Parametrised register file with two combinational read ports, one write port,
// a fixed tap output and a valid/ready engine that streams every register out.
module reg_file_dump #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TAP_REG    = 10,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ad1,
  input  logic [ADDR_WIDTH-1:0] ad2,
  input  logic [ADDR_WIDTH-1:0] ad3,
  input  logic                  regwrite,
  input  logic [DATA_WIDTH-1:0] wd3,
  output logic [DATA_WIDTH-1:0] regop1,
  output logic [DATA_WIDTH-1:0] regop2,
  output logic [DATA_WIDTH-1:0] a0,
  input  logic                  dump_start,
  output logic                  dump_busy,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_idx,
  output logic [DATA_WIDTH-1:0] dump_data
);

  localparam int NREGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NREGS - 1);
  localparam logic [ADDR_WIDTH-1:0] TAP_IDX  = ADDR_WIDTH'(TAP_REG);

  typedef enum logic {IDLE, DUMP} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] idx, idx_nx;
  logic [DATA_WIDTH-1:0] rf [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (regwrite && (ad3 != '0)) begin
      rf[ad3] <= wd3;
    end
  end

  // Register 0 reads as zero even when the bypass would otherwise forward into it.
  always_comb begin
    regop1 = '0;
    if (ad1 != '0) begin
      if ((BYPASS != 0) && regwrite && (ad3 == ad1)) regop1 = wd3;
      else                                           regop1 = rf[ad1];
    end
  end

  always_comb begin
    regop2 = '0;
    if (ad2 != '0) begin
      if ((BYPASS != 0) && regwrite && (ad3 == ad2)) regop2 = wd3;
      else                                           regop2 = rf[ad2];
    end
  end

  assign a0        = rf[TAP_IDX];
  assign dump_idx  = idx;
  assign dump_data = rf[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    case (state)
      IDLE: begin
        if (dump_start) begin
          state_nx = DUMP;
          idx_nx   = '0;
        end
      end
      DUMP: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        if (dump_ready) begin
          if (idx == LAST_IDX) begin
            state_nx = IDLE;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + ADDR_WIDTH'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase
  end

endmodule
